// File: rtl/hack_pkg.sv
// Shared Hack-platform definitions: default word width and the RAM clear FSM states.
package hack_pkg;

    localparam int unsigned HACK_WORD_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/dmux_np.sv
// N-way demultiplexer: routes one load bit (and its data word) to the output
// selected by address; all other outputs are zero.
module dmux_np #(
    parameter int unsigned N = 8,
    parameter int unsigned D = 16
) (
    input  logic                  load,
    input  logic [$clog2(N)-1:0]  address,
    input  logic [D-1:0]          data,
    output logic [N-1:0]          load_vec,
    output logic [N-1:0][D-1:0]   data_vec
);

    localparam int unsigned A = $clog2(N);

    always_comb begin
        load_vec = '0;
        data_vec = '0;
        for (int i = 0; i < N; i++) begin
            load_vec[i] = load && (address == A'(i));
            data_vec[i] = load_vec[i] ? data : '0;
        end
    end

endmodule

// File: rtl/ram_np.sv
// Hack-style N x D RAM with combinational read. Define RAM_CLEAR_EN to add the
// post-reset clear sweep (o_busy high while memory is being zeroed).
module ram_np
    import hack_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned D = HACK_WORD_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [D-1:0]          i_in,
    input  logic                  i_load,
    input  logic [$clog2(N)-1:0]  i_address,
    output logic [D-1:0]          o_out,
    output logic                  o_busy
);

    localparam int unsigned A = $clog2(N);

    logic                 busy;
    logic                 wr_load;
    logic [A-1:0]         wr_addr;
    logic [D-1:0]         wr_word;
    logic [N-1:0]         word_load;
    logic [N-1:0][D-1:0]  word_in;
    logic [D-1:0]         mem [N];

`ifdef RAM_CLEAR_EN
    localparam logic [A-1:0] LastAddr = A'(N - 1);

    clr_state_e   state_q, state_d;
    logic [A-1:0] ptr_q, ptr_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Stop on the last word rather than wrapping; ptr then holds in IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLEAR) begin
            if (ptr_q == LastAddr) begin
                state_d = IDLE;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    assign busy    = (state_q == CLEAR);
    assign wr_load = busy | i_load;
    assign wr_addr = busy ? ptr_q : i_address;
    assign wr_word = busy ? '0 : i_in;
`else
    // No sweep: writes are held off only while reset is asserted.
    assign busy    = 1'b0;
    assign wr_load = i_load & ~i_rst;
    assign wr_addr = i_address;
    assign wr_word = i_in;
`endif

    dmux_np #(
        .N (N),
        .D (D)
    ) u_dmux (
        .load     (wr_load),
        .address  (wr_addr),
        .data     (wr_word),
        .load_vec (word_load),
        .data_vec (word_in)
    );

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N; i++) begin
            if (word_load[i]) begin
                mem[i] <= word_in[i];
            end
        end
    end

    assign o_out  = busy ? '0 : mem[i_address];
    assign o_busy = busy;

endmodule

// File: tb/tb_ram_np.sv
// Randomised self-checking bench for ram_np (N=8, D=16); follows RAM_CLEAR_EN
// to choose between sweep and no-sweep expectations.
module tb_ram_np;

    localparam int unsigned N = 8;
    localparam int unsigned D = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic [D-1:0]  i_in = '0;
    logic          i_load = 1'b0;
    logic [2:0]    i_address = '0;
    logic [D-1:0]  o_out;
    logic          o_busy;

    logic [D-1:0]  model [N];
    bit            valid [N];
    int            n_checks = 0;
    int            n_fails = 0;

    ram_np #(
        .N (N),
        .D (D)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_in      (i_in),
        .i_load    (i_load),
        .i_address (i_address),
        .o_out     (o_out),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [D-1:0] data);
        i_address = addr;
        i_in      = data;
        i_load    = 1'b1;
        tick();
        i_load    = 1'b0;
        model[addr] = data;
        valid[addr] = 1'b1;
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < N; a++) begin
            i_address = a[2:0];
            #1;
            if (valid[a]) check(tag, {16'h0, o_out}, {16'h0, model[a]});
            check({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < N; a++) begin
            model[a] = '0;
            valid[a] = 1'b1;
        end
    endtask

    // Counts edges while busy; output must read zero throughout. Optionally
    // tries a write of 0xFFFF to address 0 on sweep cycle 2.
    task automatic run_sweep(input string tag, input bit poke);
        int          cnt;
        logic [31:0] r;
        cnt = 0;
        for (int k = 0; k < N + 4; k++) begin
            if (o_busy !== 1'b1) break;
            r         = $urandom;
            i_address = (poke && k == 2) ? 3'd0 : r[2:0];
            i_in      = 16'hFFFF;
            i_load    = poke && (k == 2);
            #1;
            check({tag, "_out0"}, {16'h0, o_out}, 32'h0);
            tick();
            cnt++;
        end
        i_load = 1'b0;
        check({tag, "_len"}, cnt, N);
        model_clear();
    endtask

    task automatic random_ops(input string tag, input int count);
        logic [31:0] r;
        logic [2:0]  a;
        for (int k = 0; k < count; k++) begin
            r         = $urandom;
            a         = r[2:0];
            i_address = a;
            i_in      = r[31:16];
            i_load    = r[3];
            #1;
            if (valid[a]) check({tag, "_rd"}, {16'h0, o_out}, {16'h0, model[a]});
            check({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
            tick();
            if (r[3]) begin
                model[a] = r[31:16];
                valid[a] = 1'b1;
            end
        end
        i_load = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < N; a++) begin
            model[a] = '0;
            valid[a] = 1'b0;
        end
        #2 i_rst = 1'b1;
        #1;
`ifdef RAM_CLEAR_EN
        check("rst_busy", {31'h0, o_busy}, 32'h1);
        check("rst_out", {16'h0, o_out}, 32'h0);
        tick();
        tick();
        check("rst_busy_clk", {31'h0, o_busy}, 32'h1);
        i_rst = 1'b0;
        run_sweep("sweep", 1'b1);
        read_all("sweep_rd");

        do_write(3'd3, 16'hBEEF);
        do_write(3'd5, 16'h1234);
        read_all("wr_rd");

        do_write(3'd2, 16'h00AA);
        i_address = 3'd2;
        i_in      = 16'h5555;
        i_load    = 1'b1;
        #1;
        check("raw_old", {16'h0, o_out}, 32'h00AA);
        tick();
        i_load = 1'b0;
        check("raw_new", {16'h0, o_out}, 32'h5555);
        model[2] = 16'h5555;

        random_ops("rnd1", 40);
        read_all("rnd1_all");

        // Reset from IDLE with live data, then again mid-sweep.
        i_rst = 1'b1;
        #1;
        check("idle_rst_busy", {31'h0, o_busy}, 32'h1);
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("mid_busy", {31'h0, o_busy}, 32'h1);
        i_rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'h0, o_busy}, 32'h1);
        tick();
        i_rst = 1'b0;
        run_sweep("resweep", 1'b0);
        read_all("resweep_rd");

        random_ops("rnd2", 30);
        read_all("rnd2_all");
`else
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        tick();
        i_address = 3'd7;
        i_in      = 16'h7FFF;
        i_load    = 1'b1;
        i_rst     = 1'b0;
        #1;
        check("first_busy", {31'h0, o_busy}, 32'h0);
        tick();
        i_load = 1'b0;
        model[7] = 16'h7FFF;
        valid[7] = 1'b1;
        check("first_wr", {16'h0, o_out}, 32'h7FFF);

        do_write(3'd2, 16'h00AA);
        i_address = 3'd2;
        i_in      = 16'h5555;
        i_load    = 1'b1;
        #1;
        check("raw_old", {16'h0, o_out}, 32'h00AA);
        tick();
        i_load = 1'b0;
        check("raw_new", {16'h0, o_out}, 32'h5555);
        model[2] = 16'h5555;

        random_ops("rnd1", 60);
        for (int a = 0; a < N; a++) do_write(a[2:0], 16'(a * 16'h1111 + 16'h0101));
        read_all("all_rd");
        random_ops("rnd2", 30);
        read_all("rnd2_all");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
